// File: rtl/prefetch_line_buffer_pkg.sv
// Shared types and constants for the prefetch line buffer and its line store.
package prefetch_line_buffer_pkg;

  localparam int PF_LINE_BITS   = 256;
  localparam int PF_OFFSET_BITS = 5;

  typedef logic [26:0] pf_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    HIT_RESP,
    DEMAND,
    PREFETCH
  } pfb_state_t;

  function automatic pf_tag_t pf_tag_of(input logic [31:0] addr);
    return addr[31:PF_OFFSET_BITS];
  endfunction

  function automatic logic [31:0] pf_sat_add(input logic [31:0] v, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, v} + {31'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/prefetch_line_buffer_line_store.sv
// Fully-associative line store: valid/tag/data arrays, two tag lookup ports and
// round-robin (FIFO order) allocation.
module pf_line_store
  import prefetch_line_buffer_pkg::*;
#(
  parameter int NUM_ENTRIES = 2,
  parameter int LINE_BITS   = PF_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  pf_tag_t              lk_a_tag,
  output logic                 lk_a_hit,
  output logic [LINE_BITS-1:0] lk_a_data,
  input  pf_tag_t              lk_b_tag,
  output logic                 lk_b_hit,
  input  logic                 alloc_en,
  input  pf_tag_t              alloc_tag,
  input  logic [LINE_BITS-1:0] alloc_data
);

  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] hit_a_vec;
  logic [NUM_ENTRIES-1:0] hit_b_vec;
  pf_tag_t                tag_q  [NUM_ENTRIES];
  logic [LINE_BITS-1:0]   data_q [NUM_ENTRIES];
  logic [PTR_W-1:0]       ptr_q;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
    assign hit_a_vec[gi] = valid_q[gi] && (tag_q[gi] == lk_a_tag);
    assign hit_b_vec[gi] = valid_q[gi] && (tag_q[gi] == lk_b_tag);
  end

  assign lk_a_hit = |hit_a_vec;
  assign lk_b_hit = |hit_b_vec;

  // Tags are unique among valid entries, so an OR of the gated lines is the hit line.
  always_comb begin
    lk_a_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (hit_a_vec[i]) lk_a_data = lk_a_data | data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (alloc_en) begin
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= (ptr_q == PTR_W'(NUM_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) begin
      tag_q[ptr_q]  <= alloc_tag;
      data_q[ptr_q] <= alloc_data;
    end
  end

endmodule

// File: rtl/prefetch_line_buffer.sv
// Next-line prefetch buffer between the I-cache miss port and memory.
// Define PF_STATS_EN to add saturating issued/hit/drop counter outputs.
module prefetch_line_buffer
  import prefetch_line_buffer_pkg::*;
#(
  parameter int NUM_ENTRIES = 2,
  parameter int LINE_BITS   = PF_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pf_valid,
  input  logic [31:0]          pf_addr,
  input  logic                 flush,
  input  logic [31:0]          cache_addr,
  input  logic                 cache_read,
  output logic [LINE_BITS-1:0] cache_rdata,
  output logic                 cache_resp,
  output logic [31:0]          mem_addr,
  output logic                 mem_read,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_resp,
  output logic [31:0]          stream_addr
`ifdef PF_STATS_EN
  ,
  output logic [31:0]          pf_issued_cnt,
  output logic [31:0]          pf_hit_cnt,
  output logic [31:0]          pf_drop_cnt
`endif
);

  pfb_state_t           state_q;
  logic                 mem_read_q, flushed_q;
  logic [31:0]          mem_addr_q, stream_addr_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 pend_valid_q, pend_valid_d;
  pf_tag_t              pend_tag_q, pend_tag_d;

  pf_tag_t              cache_tag, pf_tag, infl_tag;
  logic                 hit_a, hit_b;
  logic [LINE_BITS-1:0] hit_data;
  logic                 is_idle, is_prefetch, issue, pf_infl, pf_load;
  logic                 pf_done, pf_discard, infl_fwd, dem_done, alloc_en;
  logic                 unused_pf_offset;

  assign cache_tag        = pf_tag_of(cache_addr);
  assign pf_tag           = pf_tag_of(pf_addr);
  assign infl_tag         = pf_tag_of(mem_addr_q);
  assign unused_pf_offset = ^pf_addr[PF_OFFSET_BITS-1:0];

  assign is_idle     = (state_q == IDLE);
  assign is_prefetch = (state_q == PREFETCH);
  // A flush in the same cycle kills the pending request before it can issue.
  assign issue       = is_idle && !cache_read && pend_valid_q && !flush;
  assign pf_infl     = (is_prefetch && pf_tag == infl_tag) || (issue && pf_tag == pend_tag_q);
  assign pf_load     = pf_valid && !flush && !hit_b && !pf_infl;
  assign pf_done     = is_prefetch && mem_resp;
  assign pf_discard  = flushed_q || flush;
  assign infl_fwd    = pf_done && cache_read && (cache_tag == infl_tag);
  assign dem_done    = (state_q == DEMAND) && mem_resp;
  assign alloc_en    = pf_done && !pf_discard;

  pf_line_store #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .LINE_BITS  (LINE_BITS)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_a_tag  (cache_tag),
    .lk_a_hit  (hit_a),
    .lk_a_data (hit_data),
    .lk_b_tag  (pf_tag),
    .lk_b_hit  (hit_b),
    .alloc_en  (alloc_en),
    .alloc_tag (infl_tag),
    .alloc_data(mem_rdata)
  );

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_tag_d   = pend_tag_q;
    if (flush) begin
      pend_valid_d = 1'b0;
    end else if (pf_load) begin
      pend_valid_d = 1'b1;
      pend_tag_d   = pf_tag;
    end else if (issue) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= '0;
      stream_addr_q <= '0;
      rdata_q       <= '0;
      flushed_q     <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_tag_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
      case (state_q)
        IDLE: begin
          if (cache_read && hit_a) begin
            state_q <= HIT_RESP;
            rdata_q <= hit_data;
          end else if (cache_read) begin
            state_q       <= DEMAND;
            mem_read_q    <= 1'b1;
            mem_addr_q    <= cache_addr;
            stream_addr_q <= cache_addr;
          end else if (issue) begin
            state_q    <= PREFETCH;
            mem_read_q <= 1'b1;
            mem_addr_q <= {pend_tag_q, {PF_OFFSET_BITS{1'b0}}};
            flushed_q  <= 1'b0;
          end
        end
        HIT_RESP: state_q <= IDLE;
        DEMAND: begin
          if (mem_resp) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
        PREFETCH: begin
          if (mem_resp) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            flushed_q  <= 1'b0;
          end else if (flush) begin
            flushed_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Memory-sourced responses bypass the registered hit data in the mem_resp cycle.
  assign cache_resp  = (state_q == HIT_RESP) || dem_done || infl_fwd;
  assign cache_rdata = (dem_done || infl_fwd) ? mem_rdata : rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_addr    = mem_addr_q;
  assign stream_addr = stream_addr_q;

`ifdef PF_STATS_EN
  logic [31:0] issued_q, hits_q, drops_q;
  logic        pend_drop, resp_drop, hit_evt;

  assign pend_drop = pend_valid_q && (flush || (pf_load && !issue));
  assign resp_drop = pf_done && pf_discard;
  assign hit_evt   = (is_idle && cache_read && hit_a) || infl_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      hits_q   <= '0;
      drops_q  <= '0;
    end else begin
      issued_q <= pf_sat_add(issued_q, {1'b0, issue});
      hits_q   <= pf_sat_add(hits_q, {1'b0, hit_evt});
      drops_q  <= pf_sat_add(drops_q, {1'b0, pend_drop} + {1'b0, resp_drop});
    end
  end

  assign pf_issued_cnt = issued_q;
  assign pf_hit_cnt    = hits_q;
  assign pf_drop_cnt   = drops_q;
`endif

endmodule

// File: tb/tb_prefetch_line_buffer.sv
// Self-checking bench: vector table, directed corner sequences, then random
// prefetch/read traffic against a FIFO-of-lines reference model.
module tb_prefetch_line_buffer;

  localparam int N = 2;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         pf_valid = 1'b0, flush = 1'b0, cache_read = 1'b0, mem_resp = 1'b0;
  logic [31:0]  pf_addr = '0, cache_addr = '0;
  logic [255:0] mem_rdata = '0;
  logic [255:0] cache_rdata;
  logic         cache_resp, mem_read;
  logic [31:0]  mem_addr, stream_addr;
`ifdef PF_STATS_EN
  logic [31:0]  pf_issued_cnt, pf_hit_cnt, pf_drop_cnt;
`endif

  int total = 0, bad = 0, mem_reads = 0, mem_lat = 2;

  prefetch_line_buffer #(.NUM_ENTRIES(N), .LINE_BITS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pf_valid   (pf_valid),
    .pf_addr    (pf_addr),
    .flush      (flush),
    .cache_addr (cache_addr),
    .cache_read (cache_read),
    .cache_rdata(cache_rdata),
    .cache_resp (cache_resp),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .stream_addr(stream_addr)
`ifdef PF_STATS_EN
    ,
    .pf_issued_cnt(pf_issued_cnt),
    .pf_hit_cnt   (pf_hit_cnt),
    .pf_drop_cnt  (pf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (32'h9E37_79B9 * (k + 1));
    return l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Memory: accepts a read at a falling edge, answers mem_lat cycles later.
  int          mcnt = 0;
  logic        mbusy = 1'b0;
  logic [31:0] maddr = '0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_resp = 1'b0;
      mbusy    = 1'b0;
      mcnt     = 0;
    end else begin
      mem_resp = 1'b0;
      if (mem_read) begin
        if (!mbusy) begin
          mbusy = 1'b1;
          mcnt  = mem_lat;
          maddr = mem_addr;
          mem_reads++;
        end else begin
          chk("mem_addr_stable", 256'(mem_addr), 256'(maddr));
        end
        if (mcnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = line_of(maddr);
          mbusy     = 1'b0;
        end else begin
          mcnt--;
        end
      end else begin
        mbusy = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (cache_resp) chk("resp_needs_read", 256'(cache_read), 256'(1'b1));
  end

  // Called at a falling edge; returns at a falling edge after cache_read drops.
  task automatic cache_req(input logic [31:0] a, output logic [255:0] d, output int lat,
                           output logic with_mem);
    logic got;
    got = 1'b0; d = '0; lat = 0; with_mem = 1'b0;
    cache_read = 1'b1;
    cache_addr = a;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (cache_resp) begin
        d = cache_rdata;
        with_mem = mem_resp;
        got = 1'b1;
        break;
      end
      @(negedge clk);
      pf_valid = 1'b0;
      lat++;
    end
    chk("cache_resp_timeout", 256'(got), 256'(1'b1));
    @(negedge clk);
    cache_read = 1'b0;
    pf_valid   = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_stream);
    int r0, lat;
    logic [255:0] d;
    logic wm;
    r0 = mem_reads;
    cache_req(a, d, lat, wm);
    chk("rd_data", d, line_of(a));
    chkn("rd_mem_reads", mem_reads - r0, exp_hit ? 0 : 1);
    if (exp_hit) chkn("rd_hit_latency", lat, 1);
    chk("rd_resp_with_mem", 256'(wm), 256'(!exp_hit));
    chk("rd_stream_addr", 256'(stream_addr), 256'(exp_stream));
    $display("rd   addr=%h hit=%0d lat=%0d stream=%h", a, exp_hit, lat, stream_addr);
  endtask

  task automatic do_pf(input logic [31:0] a, input int exp_reads);
    int r0;
    r0 = mem_reads;
    pf_valid = 1'b1;
    pf_addr  = a;
    @(negedge clk);
    pf_valid = 1'b0;
    repeat (mem_lat + 6) @(negedge clk);
    chkn("pf_mem_reads", mem_reads - r0, exp_reads);
    chk("pf_mem_idle", 256'(mem_read), 256'(1'b0));
    $display("pf   addr=%h reads=%0d", a, mem_reads - r0);
  endtask

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic        exp_hit;
    int          exp_reads;
    logic [31:0] exp_stream;
    int          lat;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d;
    int lat, r0;
    logic wm, hit;
    logic [31:0] a, last_miss;
    logic [31:0] model_q[$];

    tbl[0]  = '{1'b0, 32'h1000, 1'b0, 1, 32'h0,    5};
    tbl[1]  = '{1'b1, 32'h1000, 1'b1, 0, 32'h0,    2};
    tbl[2]  = '{1'b1, 32'h2040, 1'b0, 1, 32'h2040, 3};
    tbl[3]  = '{1'b1, 32'h2040, 1'b0, 1, 32'h2040, 0};
    tbl[4]  = '{1'b0, 32'h0100, 1'b0, 1, 32'h0,    1};
    tbl[5]  = '{1'b0, 32'h0120, 1'b0, 1, 32'h0,    0};
    tbl[6]  = '{1'b0, 32'h0140, 1'b0, 1, 32'h0,    2};
    tbl[7]  = '{1'b1, 32'h0100, 1'b0, 1, 32'h0100, 1};
    tbl[8]  = '{1'b1, 32'h0120, 1'b1, 0, 32'h0100, 2};
    tbl[9]  = '{1'b1, 32'h0140, 1'b1, 0, 32'h0100, 2};
    tbl[10] = '{1'b0, 32'h0140, 1'b0, 0, 32'h0,    2};
    tbl[11] = '{1'b1, 32'h1000, 1'b0, 1, 32'h1000, 2};
    tbl[12] = '{1'b0, 32'h1000, 1'b0, 1, 32'h0,    3};
    tbl[13] = '{1'b1, 32'h0120, 1'b0, 1, 32'h0120, 2};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cache_resp", 256'(cache_resp), 256'(1'b0));
    chk("rst_cache_rdata", cache_rdata, 256'd0);
    chk("rst_mem_read", 256'(mem_read), 256'(1'b0));
    chk("rst_mem_addr", 256'(mem_addr), 256'd0);
    chk("rst_stream_addr", 256'(stream_addr), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      mem_lat = tbl[i].lat;
      if (tbl[i].is_rd) do_read(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_stream);
      else do_pf(tbl[i].addr, tbl[i].exp_reads);
    end

    // In-flight match: demand for the line being prefetched shares the read
    mem_lat = 6;
    r0 = mem_reads;
    pf_valid = 1'b1;
    pf_addr  = 32'h3000;
    @(negedge clk);
    pf_valid = 1'b0;
    repeat (3) @(negedge clk);
    cache_req(32'h3000, d, lat, wm);
    chk("infl_data", d, line_of(32'h3000));
    chk("infl_resp_with_mem", 256'(wm), 256'(1'b1));
    chkn("infl_single_read", mem_reads - r0, 1);
    $display("infl addr=00003000 lat=%0d", lat);
    repeat (4) @(negedge clk);
    do_read(32'h3000, 1'b1, 32'h0120);

    // Flush during prefetch: read completes, line is not kept
    r0 = mem_reads;
    pf_valid = 1'b1;
    pf_addr  = 32'h4000;
    @(negedge clk);
    pf_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_mem_read_held", 256'(mem_read), 256'(1'b1));
    chk("flush_mem_addr_held", 256'(mem_addr), 256'(32'h4000));
    repeat (10) @(negedge clk);
    chkn("flush_reads", mem_reads - r0, 1);
    $display("flsh addr=00004000 reads=%0d", mem_reads - r0);
    do_read(32'h4000, 1'b0, 32'h4000);
    do_read(32'h1000, 1'b1, 32'h4000);
    do_read(32'h3000, 1'b1, 32'h4000);

    // Demand and prefetch request in the same cycle: demand first
    mem_lat = 3;
    r0 = mem_reads;
    pf_valid = 1'b1;
    pf_addr  = 32'h5000;
    cache_req(32'h6000, d, lat, wm);
    chk("dual_data", d, line_of(32'h6000));
    chk("dual_resp_with_mem", 256'(wm), 256'(1'b1));
    chkn("dual_demand_only", mem_reads - r0, 1);
    chk("dual_stream", 256'(stream_addr), 256'(32'h6000));
    @(negedge clk);
    #1;
    chk("dual_pf_read", 256'(mem_read), 256'(1'b1));
    chk("dual_pf_addr", 256'(mem_addr), 256'(32'h5000));
    $display("dual demand=00006000 then pf=%h", mem_addr);
    repeat (8) @(negedge clk);
    do_read(32'h5000, 1'b1, 32'h6000);

    // Asynchronous reset in the middle of a demand miss
    mem_lat = 20;
    cache_read = 1'b1;
    cache_addr = 32'h7000;
    repeat (3) @(negedge clk);
    #1;
    chk("arst_pre_mem_read", 256'(mem_read), 256'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_read", 256'(mem_read), 256'(1'b0));
    chk("arst_cache_resp", 256'(cache_resp), 256'(1'b0));
    chk("arst_stream", 256'(stream_addr), 256'd0);
    $display("arst mid-demand addr=00007000");
    cache_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 2;
    repeat (2) @(negedge clk);
    do_read(32'h1000, 1'b0, 32'h1000);
    do_read(32'h5000, 1'b0, 32'h5000);

    // Random traffic against a FIFO-of-lines model
    last_miss = 32'h5000;
    for (int n = 0; n < 60; n++) begin
      mem_lat = int'($urandom_range(0, 4));
      a = 32'h8000 + 32'($urandom_range(0, 5) << 5);
      hit = 1'b0;
      foreach (model_q[k]) if (model_q[k] == a) hit = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        do_pf(a, hit ? 0 : 1);
        if (!hit) begin
          model_q.push_back(a);
          if (model_q.size() > N) void'(model_q.pop_front());
        end
      end else begin
        if (!hit) last_miss = a;
        do_read(a, hit, last_miss);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_line_buffer.md
Name: prefetch_line_buffer

Overview:
- Sits between the I-cache miss port (DFP) and memory, downstream of the next-line prefetch-address generator.
- Consumes its one-cycle prefetch request (address, already 32-byte aligned), fetches that line from memory while the cache is idle, and holds it in a small fully-associative buffer.
- Serves later cache misses from the buffer in one cycle. Forwards true misses to memory and reports each demand-miss address back upstream for direction detection.

Parameters:
- NUM_ENTRIES, 2, number of buffered 256-bit lines (power of 2, 1..8).
- LINE_BITS, 256, line width in bits; the address offset is 5 bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pf_valid  input  1  one-cycle prefetch request pulse
- pf_addr  input  32  prefetch line address; bits [4:0] are ignored
- flush  input  1  branch/redirect; drops pending and in-flight prefetch data
- cache_addr  input  32  cache miss address (line aligned)
- cache_read  input  1  cache miss request, level, held until cache_resp
- cache_rdata  output  256  returned line
- cache_resp  output  1  one-cycle response
- mem_addr  output  32  memory read address
- mem_read  output  1  memory read, level, held until mem_resp
- mem_rdata  input  256  memory line
- mem_resp  input  1  one-cycle memory response
- stream_addr  output  32  last demand-miss line address, registered; 0 until the first miss

Behaviour:
- Reset (async, rst_n=0): all entries invalid, FIFO pointer 0, pending cleared, state IDLE.
- Reset values: cache_resp=0, cache_rdata=0, mem_read=0, mem_addr=0, stream_addr=0.
- Reset mid-transaction drops mem_read immediately. The memory model must tolerate this.
- Lookup: combinational tag compare of cache_addr[31:5] or pending address against all valid entries.
- Pending register: 1 deep.
  - pf_valid loads it unless the address hits the buffer or equals the in-flight address.
  - A newer pf_valid overwrites an older pending request.
  - flush clears it. If flush and pf_valid arrive in the same cycle, flush wins.
- States: IDLE, HIT_RESP, DEMAND, PREFETCH.
- IDLE:
  - cache_read and buffer hit -> HIT_RESP.
  - cache_read and miss -> DEMAND. mem_addr=cache_addr, mem_read=1. stream_addr<=cache_addr the next cycle.
  - No cache_read and pending valid -> PREFETCH. mem_addr=pending address, mem_read=1, pending cleared.
  - A demand request always beats pending; pending is kept.
- HIT_RESP:
  - cache_resp=1 for exactly one cycle with the entry data. Latency is 1 cycle from the first cycle of cache_read.
  - The entry stays valid. Return to IDLE.
- DEMAND:
  - On mem_resp: cache_resp=1 and cache_rdata=mem_rdata in the same cycle, then IDLE.
  - The line is not allocated in the buffer; the cache owns it.
- PREFETCH:
  - On mem_resp: write the line into the entry at the FIFO pointer and advance the pointer (wraps at NUM_ENTRIES). Go to IDLE.
  - If flush occurred at any point during PREFETCH, the response is discarded with no allocation. mem_read still completes.
  - If cache_read arrives during PREFETCH:
    - Address equals the in-flight address: on mem_resp, forward to the cache the same cycle and also allocate (unless flushed).
    - Otherwise: finish the prefetch, then handle as IDLE.
- The memory side never issues a second read before mem_resp. mem_addr and mem_read hold stable while waiting.
- cache_resp never asserts without cache_read. cache_read falling is ignored except as above.

Optional Feature:
- PF_STATS_EN
  - Defined: adds 32-bit saturating output ports pf_issued_cnt, pf_hit_cnt and pf_drop_cnt.
    - pf_issued_cnt: prefetches sent to memory.
    - pf_hit_cnt: demand requests served from the buffer or from an in-flight match.
    - pf_drop_cnt: pending requests overwritten or flushed, plus flushed responses.
    - All three clear on reset.
  - Undefined: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Shared package holds:
  - typedef pfb_state_t (IDLE, HIT_RESP, DEMAND, PREFETCH).
  - localparams PF_LINE_BITS=256 and PF_OFFSET_BITS=5.
  - typedef pf_tag_t = logic[26:0].
- One sub-module, pf_line_store, holds the tag/valid/data arrays, the dual lookup ports (cache and pending) and FIFO allocation. The top holds the FSM, pending register, stream_addr and stats.

Test Plan:
- Prefetch-then-hit: pf_valid pf_addr=0x1000, mem_resp after 5 cycles. Then cache_read 0x1000 -> cache_resp the next cycle with that line, mem_read stays 0.
- Demand miss: cache_read 0x2040 in IDLE -> mem_read=1 with mem_addr=0x2040. cache_resp coincides with mem_resp. stream_addr=0x2040 afterwards, and the buffer is unchanged.
- In-flight match: prefetch 0x3000 issued, cache_read 0x3000 two cycles later -> single memory read, cache_resp on the mem_resp cycle, and a later cache_read 0x3000 hits.
- Flush during prefetch: prefetch 0x4000 issued, flush pulse -> mem_read held until mem_resp, no allocation, and cache_read 0x4000 then goes to memory.
- FIFO wrap with NUM_ENTRIES=2: prefetch 0x100, 0x120, 0x140 -> 0x100 evicted, 0x120 and 0x140 hit. Also check: demand and pf_valid in the same cycle -> demand first, then prefetch.
- Async reset: assert rst_n=0 mid-DEMAND -> mem_read and cache_resp drop with no clock edge, and all entries miss afterwards.
